wb_uart_tx_fifo: RTL and testbench

WB_UART_TX_FIFO -- requirements
Module: wb_uart_tx_fifo

---
 rtl/wb_uart_tx_fifo.sv | 171 +++++++++++++++++
 tb/tb_wb_uart_tx_fifo.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_uart_tx_fifo.sv
// Wishbone-style UART transmitter with a small TX FIFO, W1C status register
// (TI / OVF) and an 8N1 serializer running at BAUD_PERIOD clocks per bit.
module wb_uart_tx_fifo #(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned BAUD_PERIOD     = 868,
  parameter logic [7:0]  REG_ADDR_TXDATA = 8'h99,
  parameter logic [7:0]  REG_ADDR_TXSTAT = 8'h98
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stb_i,
  input  logic       we_i,
  input  logic [7:0] adr_wr_i,
  input  logic [7:0] adr_rd_i,
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o,
  output logic       ack_o,
  output logic       UART_TXD,
  output logic       SCON_TI,
  output logic       tx_busy
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMR_W = (BAUD_PERIOD > 1) ? $clog2(BAUD_PERIOD) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             ti_q, ti_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;

  logic wr_data_c, wr_stat_c, empty_c, full_c, push_c, pop_c, timer_done_c, ti_set_c;

  assign wr_data_c    = stb_i & we_i & (adr_wr_i == REG_ADDR_TXDATA);
  assign wr_stat_c    = stb_i & we_i & (adr_wr_i == REG_ADDR_TXSTAT);
  assign empty_c      = (count_q == '0);
  assign full_c       = (count_q == CNT_W'(FIFO_DEPTH));
  assign push_c       = wr_data_c & ~full_c;
  assign pop_c        = (state_q == S_IDLE) & ~empty_c;
  assign timer_done_c = (timer_q == TMR_W'(BAUD_PERIOD - 1));

  // Zero-wait-state bus: ack and read data are combinational
  assign ack_o = stb_i;

  always_comb begin
    dat_o = 8'h00;
    if (adr_rd_i == REG_ADDR_TXSTAT) begin
      dat_o = {3'b000, ovf_q, busy_q, full_c, empty_c, ti_q};
    end
  end

  assign UART_TXD = txd_q;
  assign SCON_TI  = ti_q;
  assign tx_busy  = busy_q;

  // FIFO pointer/count bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= dat_i;
  end

  // Serializer next-state; txd is computed one cycle ahead so the line is registered
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_done_c ? '0 : timer_q + TMR_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    ti_set_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        txd_d   = 1'b1;
        if (pop_c) begin
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
          txd_d   = 1'b0;
        end
      end
      S_START: begin
        if (timer_done_c) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
          txd_d     = shift_q[0];
        end
      end
      S_DATA: begin
        if (timer_done_c) begin
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shift_q[1];
          end
        end
      end
      S_STOP: begin
        txd_d = 1'b1;
        if (timer_done_c) begin
          state_d  = S_IDLE;
          ti_set_c = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Sticky flags: a set in the same cycle as a W1C clear wins
  assign ti_d  = ti_set_c | (ti_q & ~(wr_stat_c & dat_i[0]));
  assign ovf_d = (wr_data_c & full_c) | (ovf_q & ~(wr_stat_c & dat_i[4]));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      txd_q     <= 1'b1;
      ti_q      <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      ti_q      <= ti_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_wb_uart_tx_fifo.sv
// Bench for wb_uart_tx_fifo: bus writes feed an expected-byte queue, a line
// monitor captures 40-sample frames, and each scenario task compares them.
module tb_wb_uart_tx_fifo;

  localparam logic [7:0] A_DATA = 8'h99;
  localparam logic [7:0] A_STAT = 8'h98;

  logic       clk = 1'b0;
  logic       reset;
  logic       stb_i, we_i;
  logic [7:0] adr_wr_i, adr_rd_i, dat_i;
  logic [7:0] dat_o;
  logic       ack_o, UART_TXD, SCON_TI, tx_busy;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [39:0] bits;
    int          start;
  } frame_t;

  frame_t     rx_q[$];
  logic [7:0] exp_q[$];

  wb_uart_tx_fifo #(
    .FIFO_DEPTH(4),
    .BAUD_PERIOD(4),
    .REG_ADDR_TXDATA(8'h99),
    .REG_ADDR_TXSTAT(8'h98)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stb_i(stb_i),
    .we_i(we_i),
    .adr_wr_i(adr_wr_i),
    .adr_rd_i(adr_rd_i),
    .dat_i(dat_i),
    .dat_o(dat_o),
    .ack_o(ack_o),
    .UART_TXD(UART_TXD),
    .SCON_TI(SCON_TI),
    .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  // Line monitor: one sample per cycle; a frame is the 40 samples from the start bit
  int          cyc = 0;
  bit          rx_act = 1'b0;
  int          rx_n = 0;
  int          rx_start = 0;
  logic [39:0] rx_bits;
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (UART_TXD === 1'b0) begin
        rx_act     = 1'b1;
        rx_bits    = '0;
        rx_n       = 1;
        rx_start   = cyc;
      end
    end else begin
      rx_bits[rx_n] = UART_TXD;
      rx_n++;
      if (rx_n == 40) begin
        rx_q.push_back('{bits: rx_bits, start: rx_start});
        rx_act = 1'b0;
      end
    end
  end

  // Ideal 8N1 waveform: start, LSB..MSB, stop, each held 4 samples
  function automatic logic [39:0] expand(input logic [7:0] b);
    logic [9:0]  f;
    logic [39:0] r;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 40; i++) r[i] = f[i/4];
    return r;
  endfunction

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    stb_i = 1'b1; we_i = 1'b1; adr_wr_i = a; dat_i = d;
    @(posedge clk); #1;
    stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    total++; if (UART_TXD !== 1'b1) $display("FAIL reset_txd: got %b want 1", UART_TXD); else passed++;
    total++; if (SCON_TI !== 1'b0) $display("FAIL reset_ti: got %b want 0", SCON_TI); else passed++;
    total++; if (tx_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", tx_busy); else passed++;
    total++; if (dat_o !== 8'h02) $display("FAIL reset_status: got %h want 02", dat_o); else passed++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_mux;
    logic [7:0] addrs [4] = '{8'h00, 8'h99, 8'h97, 8'hFF};
    for (int i = 0; i < 4; i++) begin
      adr_rd_i = addrs[i];
      stb_i    = i[0];
      we_i     = 1'b0;
      #1;
      total++; if (dat_o !== 8'h00) $display("FAIL rdmux_%h: got %h want 00", addrs[i], dat_o); else passed++;
      total++; if (ack_o !== i[0]) $display("FAIL ack_%0d: got %b want %b", i, ack_o, i[0]); else passed++;
      @(negedge clk);
    end
    stb_i = 1'b0;
    adr_rd_i = A_STAT;
    #1;
    total++; if (ack_o !== 1'b0) $display("FAIL ack_idle: got %b want 0", ack_o); else passed++;
  endtask

  task automatic test_single_frame;
    frame_t f;
    logic [7:0] e;
    int w;
    @(negedge clk);
    exp_q.push_back(8'hA5);
    wr(A_DATA, 8'hA5);
    @(negedge clk);
    total++; if (UART_TXD !== 1'b1) $display("FAIL lat_n1_txd: got %b want 1", UART_TXD); else passed++;
    @(negedge clk);
    total++; if (UART_TXD !== 1'b0) $display("FAIL lat_n2_txd: got %b want 0", UART_TXD); else passed++;
    total++; if (tx_busy !== 1'b1) $display("FAIL lat_n2_busy: got %b want 1", tx_busy); else passed++;
    repeat (39) @(negedge clk);
    total++; if (SCON_TI !== 1'b0) $display("FAIL ti_early: got %b want 0", SCON_TI); else passed++;
    @(negedge clk);
    total++; if (SCON_TI !== 1'b1) $display("FAIL ti_at40: got %b want 1", SCON_TI); else passed++;
    total++; if (dat_o !== 8'h03) $display("FAIL a5_status: got %h want 03", dat_o); else passed++;
    w = 0;
    while (rx_q.size() == 0 && w < 200) begin @(negedge clk); #1; w++; end
    total++;
    if (rx_q.size() == 0 || exp_q.size() == 0) $display("FAIL a5_frame: got no frame want A5");
    else begin
      f = rx_q.pop_front(); e = exp_q.pop_front();
      if (f.bits !== expand(e)) $display("FAIL a5_frame: got %h want %h", f.bits, expand(e)); else passed++;
    end
    wr(A_STAT, 8'h01);
    @(negedge clk);
    total++; if (dat_o !== 8'h02) $display("FAIL ti_w1c: got %h want 02", dat_o); else passed++;
  endtask

  task automatic test_back_to_back;
    frame_t f;
    logic [7:0] e;
    int prev_start, w;
    @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(8'(i));
      wr(A_DATA, 8'(i));
    end
    @(negedge clk);
    total++; if (dat_o !== 8'h0C) $display("FAIL b2b_full_status: got %h want 0C", dat_o); else passed++;
    prev_start = 0;
    for (int k = 0; k < 5; k++) begin
      w = 0;
      while (rx_q.size() == 0 && w < 600) begin @(negedge clk); #1; w++; end
      total++;
      if (rx_q.size() == 0 || exp_q.size() == 0) begin
        $display("FAIL b2b_frame%0d: got no frame", k);
      end else begin
        f = rx_q.pop_front(); e = exp_q.pop_front();
        if (f.bits !== expand(e)) $display("FAIL b2b_frame%0d: got %h want %h", k, f.bits, expand(e)); else passed++;
        if (k > 0) begin
          total++;
          if (f.start - prev_start !== 41) $display("FAIL b2b_gap%0d: got %0d want 41", k, f.start - prev_start); else passed++;
        end
        prev_start = f.start;
      end
    end
    @(negedge clk);
    total++; if (dat_o !== 8'h03) $display("FAIL b2b_end_status: got %h want 03", dat_o); else passed++;
    wr(A_STAT, 8'h01);
  endtask

  task automatic test_overflow;
    frame_t f;
    logic [7:0] e;
    logic prev;
    bit found;
    int w, prev_start;
    @(negedge clk);
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) exp_q.push_back(8'(8'h10 + i));
      wr(A_DATA, 8'(8'h10 + i));
    end
    @(negedge clk);
    total++; if (dat_o !== 8'h1C) $display("FAIL ovf_status: got %h want 1C", dat_o); else passed++;
    wr(A_STAT, 8'h10);
    @(negedge clk);
    total++; if (dat_o !== 8'h0C) $display("FAIL ovf_clear: got %h want 0C", dat_o); else passed++;
    // last frame is the one whose start bit appears with the FIFO already empty
    found = 1'b0;
    prev  = UART_TXD;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (prev === 1'b1 && UART_TXD === 1'b0 && dat_o[1] === 1'b1) found = 1'b1;
      prev = UART_TXD;
    end
    total++;
    if (!found) $display("FAIL ovf_last_start: got timeout want start bit");
    else begin
      passed++;
      wr(A_STAT, 8'h01);
      @(negedge clk);
      total++; if (SCON_TI !== 1'b0) $display("FAIL ovf_ti_cleared: got %b want 0", SCON_TI); else passed++;
      repeat (38) @(negedge clk);
      total++; if (SCON_TI !== 1'b0) $display("FAIL ovf_ti_prestop: got %b want 0", SCON_TI); else passed++;
      total++; if (tx_busy !== 1'b1) $display("FAIL ovf_busy_prestop: got %b want 1", tx_busy); else passed++;
      wr(A_STAT, 8'h01);
      @(negedge clk);
      total++; if (dat_o !== 8'h03) $display("FAIL ti_set_wins: got %h want 03", dat_o); else passed++;
    end
    prev_start = 0;
    for (int k = 0; k < 5; k++) begin
      w = 0;
      while (rx_q.size() == 0 && w < 600) begin @(negedge clk); #1; w++; end
      total++;
      if (rx_q.size() == 0 || exp_q.size() == 0) begin
        $display("FAIL ovf_frame%0d: got no frame", k);
      end else begin
        f = rx_q.pop_front(); e = exp_q.pop_front();
        if (f.bits !== expand(e)) $display("FAIL ovf_frame%0d: got %h want %h", k, f.bits, expand(e)); else passed++;
        if (k > 0) begin
          total++;
          if (f.start - prev_start !== 41) $display("FAIL ovf_gap%0d: got %0d want 41", k, f.start - prev_start); else passed++;
        end
        prev_start = f.start;
      end
    end
    repeat (100) @(negedge clk);
    total++; if (rx_q.size() != 0) $display("FAIL ovf_dropped: got %0d extra frames want 0", rx_q.size()); else passed++;
    wr(A_STAT, 8'h01);
  endtask

  task automatic test_reset_mid_frame;
    int lows;
    @(negedge clk);
    wr(A_DATA, 8'hC3);
    wr(A_DATA, 8'h3C);
    wr(A_DATA, 8'h77);
    @(negedge clk);
    repeat (11) @(negedge clk);
    total++; if (UART_TXD !== 1'b0) $display("FAIL rst_pre_txd: got %b want 0", UART_TXD); else passed++;
    #1 reset = 1'b1;
    #1;
    total++; if (UART_TXD !== 1'b1) $display("FAIL rst_abort_txd: got %b want 1", UART_TXD); else passed++;
    total++; if (dat_o !== 8'h02) $display("FAIL rst_abort_status: got %h want 02", dat_o); else passed++;
    total++; if (tx_busy !== 1'b0) $display("FAIL rst_abort_busy: got %b want 0", tx_busy); else passed++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (UART_TXD !== 1'b1) lows++;
    end
    total++; if (lows != 0) $display("FAIL rst_no_tx: got %0d low cycles want 0", lows); else passed++;
    total++; if (rx_q.size() != 0) $display("FAIL rst_no_frames: got %0d want 0", rx_q.size()); else passed++;
    total++; if (dat_o !== 8'h02) $display("FAIL rst_end_status: got %h want 02", dat_o); else passed++;
  endtask

  initial begin
    reset    = 1'b1;
    stb_i    = 1'b0;
    we_i     = 1'b0;
    adr_wr_i = 8'h00;
    adr_rd_i = A_STAT;
    dat_i    = 8'h00;
    test_reset;
    test_read_mux;
    test_single_frame;
    test_back_to_back;
    test_overflow;
    test_reset_mid_frame;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
